// File: rtl/mac_acc_bank.sv
// Multi-channel pipelined multiply-accumulate bank with round/shift/saturate output stage.
// Latency: 4 cycles from an ic_last beat to the oc_valid strobe; one beat accepted per cycle.
// Backpressure: none; every beat is accepted; beats on ic_ch >= NCH are dropped.
//
// Ports:
//   ic_clk, ic_rst_n           clock, synchronous active-low reset
//   id_din, id_coef            signed sample and coefficient
//   ic_valid/first/last/sub/ch beat strobe, sum start/end, subtract select, channel index
//   od_dout, oc_valid, oc_ch, oc_sat   emitted result, strobe, channel, clip flag
module mac_acc_bank #(
    parameter int Win  = 24,
    parameter int Wc   = 27,
    parameter int Wacc = 64,
    parameter int Wout = 24,
    parameter int FRAC = 23,
    parameter int NCH  = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            ic_clk,
    input  logic            ic_rst_n,
    input  logic [Win-1:0]  id_din,
    input  logic [Wc-1:0]   id_coef,
    input  logic            ic_valid,
    input  logic            ic_first,
    input  logic            ic_last,
    input  logic            ic_sub,
    input  logic [CHW-1:0]  ic_ch,
    output logic [Wout-1:0] od_dout,
    output logic            oc_valid,
    output logic [CHW-1:0]  oc_ch,
    output logic            oc_sat
);

    localparam int PW = Win + Wc;
    localparam logic [CHW:0] CH_LIM = (CHW + 1)'(NCH);
    // Rounding constant 2^(FRAC-1); zero when there is no fractional shift.
    localparam logic [Wacc:0] RND = (FRAC > 0) ? ((Wacc + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;

    // S1: registered inputs
    logic                   s1_vld_d, s1_vld_q;
    logic signed [Win-1:0]  s1_din_d, s1_din_q;
    logic signed [Wc-1:0]   s1_coef_d, s1_coef_q;
    logic                   s1_first_d, s1_first_q;
    logic                   s1_last_d, s1_last_q;
    logic                   s1_sub_d, s1_sub_q;
    logic [CHW-1:0]         s1_ch_d, s1_ch_q;

    // S2: registered product
    logic signed [PW-1:0]   prod_full;
    logic                   s2_vld_d, s2_vld_q;
    logic signed [Wacc-1:0] s2_prod_d, s2_prod_q;
    logic                   s2_first_d, s2_first_q;
    logic                   s2_last_d, s2_last_q;
    logic                   s2_sub_d, s2_sub_q;
    logic [CHW-1:0]         s2_ch_d, s2_ch_q;

    // S3: accumulator read-modify-write
    logic signed [Wacc-1:0] acc_d [NCH];
    logic signed [Wacc-1:0] acc_q [NCH];
    logic signed [Wacc-1:0] acc_base, acc_new;
    logic                   s3_vld_d, s3_vld_q;
    logic signed [Wacc-1:0] s3_sum_d, s3_sum_q;
    logic [CHW-1:0]         s3_ch_d, s3_ch_q;

    // S4: output formatting
    logic signed [Wacc:0]   rnd_sum, shifted;
    logic [Wacc-Wout+1:0]   upper;
    logic                   clip;
    logic [Wout-1:0]        od_dout_d, od_dout_q;
    logic                   oc_valid_d, oc_valid_q;
    logic [CHW-1:0]         oc_ch_d, oc_ch_q;
    logic                   oc_sat_d, oc_sat_q;

    always_comb begin
        // Out-of-range channels never enter the pipeline.
        s1_vld_d   = ic_valid && ({1'b0, ic_ch} < CH_LIM);
        s1_din_d   = id_din;
        s1_coef_d  = id_coef;
        s1_first_d = ic_first;
        s1_last_d  = ic_last;
        s1_sub_d   = ic_sub;
        s1_ch_d    = ic_ch;

        prod_full  = s1_din_q * s1_coef_q;
        s2_vld_d   = s1_vld_q;
        s2_prod_d  = Wacc'(prod_full);
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_sub_d   = s1_sub_q;
        s2_ch_d    = s1_ch_q;

        // Write-back lands before the next beat reads, so same-channel beats chain without a stall.
        acc_base = s2_first_q ? '0 : acc_q[s2_ch_q];
        acc_new  = s2_sub_q ? (acc_base - s2_prod_q) : (acc_base + s2_prod_q);
        acc_d    = acc_q;
        if (s2_vld_q) begin
            acc_d[s2_ch_q] = acc_new;
        end
        s3_vld_d = s2_vld_q && s2_last_q;
        s3_sum_d = acc_new;
        s3_ch_d  = s2_ch_q;

        // One guard bit so the rounding add cannot wrap at the top of the range.
        rnd_sum = {s3_sum_q[Wacc-1], s3_sum_q} + RND;
        shifted = rnd_sum >>> FRAC;
        // In range iff every bit from the output sign upward agrees.
        upper   = shifted[Wacc:Wout-1];
        clip    = !((&upper) || !(|upper));

        od_dout_d  = od_dout_q;
        oc_ch_d    = oc_ch_q;
        oc_sat_d   = oc_sat_q;
        oc_valid_d = s3_vld_q;
        if (s3_vld_q) begin
            oc_ch_d  = s3_ch_q;
            oc_sat_d = clip;
            if (!clip) begin
                od_dout_d = shifted[Wout-1:0];
            end else if (shifted[Wacc]) begin
                od_dout_d = {1'b1, {(Wout-1){1'b0}}};
            end else begin
                od_dout_d = {1'b0, {(Wout-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge ic_clk) begin
        if (!ic_rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_din_q   <= '0;
            s1_coef_q  <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_ch_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_prod_q  <= '0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sub_q   <= 1'b0;
            s2_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
            s3_vld_q   <= 1'b0;
            s3_sum_q   <= '0;
            s3_ch_q    <= '0;
            od_dout_q  <= '0;
            oc_valid_q <= 1'b0;
            oc_ch_q    <= '0;
            oc_sat_q   <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_din_q   <= s1_din_d;
            s1_coef_q  <= s1_coef_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_sub_q   <= s1_sub_d;
            s1_ch_q    <= s1_ch_d;
            s2_vld_q   <= s2_vld_d;
            s2_prod_q  <= s2_prod_d;
            s2_first_q <= s2_first_d;
            s2_last_q  <= s2_last_d;
            s2_sub_q   <= s2_sub_d;
            s2_ch_q    <= s2_ch_d;
            acc_q      <= acc_d;
            s3_vld_q   <= s3_vld_d;
            s3_sum_q   <= s3_sum_d;
            s3_ch_q    <= s3_ch_d;
            od_dout_q  <= od_dout_d;
            oc_valid_q <= oc_valid_d;
            oc_ch_q    <= oc_ch_d;
            oc_sat_q   <= oc_sat_d;
        end
    end

    assign od_dout  = od_dout_q;
    assign oc_valid = oc_valid_q;
    assign oc_ch    = oc_ch_q;
    assign oc_sat   = oc_sat_q;

endmodule

// File: tb/tb_mac_acc_bank.sv
// Directed bench for mac_acc_bank: default 2-channel instance plus a 3-channel instance.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Each scenario task issues beats, then watches a bounded window of cycles for strobes.
module tb_mac_acc_bank;

    localparam logic [26:0] C_ONE  = 27'h0800000;
    localparam logic [26:0] C_HALF = 27'h0400000;

    logic        clk;
    logic        rst_n;
    logic [23:0] din;
    logic [26:0] coef;
    logic        valid, first, last, sub;
    logic [1:0]  ch;

    logic [23:0] dout;
    logic        ovld, och, osat;
    logic [23:0] dout3;
    logic        ovld3, osat3;
    logic [1:0]  och3;

    int n_vec = 0;
    int n_err = 0;

    mac_acc_bank dut (
        .ic_clk  (clk),
        .ic_rst_n(rst_n),
        .id_din  (din),
        .id_coef (coef),
        .ic_valid(valid),
        .ic_first(first),
        .ic_last (last),
        .ic_sub  (sub),
        .ic_ch   (ch[0]),
        .od_dout (dout),
        .oc_valid(ovld),
        .oc_ch   (och),
        .oc_sat  (osat)
    );

    mac_acc_bank #(.NCH(3)) dut3 (
        .ic_clk  (clk),
        .ic_rst_n(rst_n),
        .id_din  (din),
        .id_coef (coef),
        .ic_valid(valid),
        .ic_first(first),
        .ic_last (last),
        .ic_sub  (sub),
        .ic_ch   (ch),
        .od_dout (dout3),
        .oc_valid(ovld3),
        .oc_ch   (och3),
        .oc_sat  (osat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] d, input logic [26:0] c,
                         input logic f, input logic l, input logic s, input logic [1:0] chan);
        din = d; coef = c; valid = 1'b1; first = f; last = l; sub = s; ch = chan;
        @(posedge clk);
        #1;
        valid = 1'b0; first = 1'b0; last = 1'b0; sub = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        n_vec++;
        if ({ovld, dout, och, osat} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b dout=%h ch=%b sat=%b, expected all zero", ovld, dout, och, osat);
        end
        n_vec++;
        if ({ovld3, dout3, och3, osat3} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs_nch3: valid=%b dout=%h ch=%h sat=%b, expected all zero", ovld3, dout3, och3, osat3);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_single_term();
        int ns = 0, kk = 0;
        logic [23:0] cd = '0;
        logic cc = 1'b1, cs = 1'b1;
        drive(24'h400000, C_ONE, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld) begin
                ns++;
                if (ns == 1) begin kk = k; cd = dout; cc = och; cs = osat; end
            end
        end
        n_vec++;
        if (ns != 1 || kk != 3) begin
            n_err++;
            $display("FAIL single_latency: %0d strobes, first at cycle %0d; expected 1 at cycle 3", ns, kk);
        end
        n_vec++;
        if ({cd, cc, cs} !== {24'h400000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_value: dout=%h ch=%b sat=%b, expected 400000/0/0", cd, cc, cs);
        end
        n_vec++;
        if (dout !== 24'h400000) begin
            n_err++;
            $display("FAIL single_hold: dout=%h after strobe, expected 400000", dout);
        end
    endtask

    task automatic test_add_sub();
        int ns = 0, kk = 0;
        logic [23:0] cd = '0;
        logic cc = 1'b0;
        drive(24'h100000, C_ONE, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(24'h100000, C_ONE, 1'b0, 1'b0, 1'b0, 2'd1);
        drive(24'h100000, C_ONE, 1'b0, 1'b1, 1'b1, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld) begin
                ns++;
                if (ns == 1) begin kk = k; cd = dout; cc = och; end
            end
        end
        n_vec++;
        if (ns != 1 || kk != 3 || cd !== 24'h100000 || cc !== 1'b1) begin
            n_err++;
            $display("FAIL add_sub: %0d strobes at %0d dout=%h ch=%b, expected 1 at 3 dout=100000 ch=1", ns, kk, cd, cc);
        end
    endtask

    task automatic test_interleave();
        int ns = 0;
        int kk [2];
        logic [23:0] cd [2];
        logic cc [2];
        drive(24'h200000, C_ONE, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(24'hE00000, C_ONE, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(24'h200000, C_ONE, 1'b0, 1'b1, 1'b0, 2'd0);
        drive(24'hE00000, C_ONE, 1'b0, 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld) begin
                if (ns < 2) begin kk[ns] = k; cd[ns] = dout; cc[ns] = och; end
                ns++;
            end
        end
        n_vec++;
        if (ns != 2 || kk[0] != 2 || kk[1] != 3) begin
            n_err++;
            $display("FAIL interleave_timing: %0d strobes at %0d,%0d; expected 2 at 2,3", ns, kk[0], kk[1]);
        end
        n_vec++;
        if (cd[0] !== 24'h400000 || cc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL interleave_ch0: dout=%h ch=%b, expected 400000/0", cd[0], cc[0]);
        end
        n_vec++;
        if (cd[1] !== 24'hC00000 || cc[1] !== 1'b1) begin
            n_err++;
            $display("FAIL interleave_ch1: dout=%h ch=%b, expected c00000/1", cd[1], cc[1]);
        end
    endtask

    // Single-term beats checked against hand-computed rounding and clipping results.
    task automatic test_saturate_round();
        logic [23:0] vd [5] = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'hFFFFFF, 24'hFFFFFD};
        logic [26:0] vc [5] = '{27'h3FFFFFF, 27'h3FFFFFF, C_HALF, C_HALF, C_HALF};
        logic [23:0] ed [5] = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'h000000, 24'hFFFFFF};
        logic        es [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int v = 0; v < 5; v++) begin
            int ns = 0;
            logic [23:0] cd = '0;
            logic cs = 1'b0;
            drive(vd[v], vc[v], 1'b1, 1'b1, 1'b0, 2'd0);
            for (int k = 1; k <= 6; k++) begin
                idle();
                if (ovld) begin ns++; cd = dout; cs = osat; end
            end
            n_vec++;
            if (ns != 1 || cd !== ed[v] || cs !== es[v]) begin
                n_err++;
                $display("FAIL sat_round[%0d]: %0d strobes dout=%h sat=%b, expected 1 dout=%h sat=%b",
                         v, ns, cd, cs, ed[v], es[v]);
            end
        end
    endtask

    task automatic test_continue();
        int ns = 0;
        logic [23:0] cd = '0;
        drive(24'h100000, C_ONE, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 6; k++) idle();
        drive(24'h100000, C_ONE, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            idle();
            if (ovld) begin ns++; cd = dout; end
        end
        n_vec++;
        if (ns != 1 || cd !== 24'h200000) begin
            n_err++;
            $display("FAIL continue_sum: %0d strobes dout=%h, expected 1 dout=200000", ns, cd);
        end
    endtask

    task automatic test_reset_mid_sum();
        int ns = 0;
        logic [23:0] cd = '0;
        drive(24'h300000, C_ONE, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(24'h300000, C_ONE, 1'b0, 1'b1, 1'b0, 2'd0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld) ns++;
        end
        n_vec++;
        if (ns != 0 || dout !== 24'h0) begin
            n_err++;
            $display("FAIL reset_discard: %0d strobes dout=%h, expected 0 strobes dout=000000", ns, dout);
        end
        drive(24'h000010, C_ONE, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            idle();
            if (ovld) begin ns++; cd = dout; end
        end
        n_vec++;
        if (ns != 1 || cd !== 24'h000010) begin
            n_err++;
            $display("FAIL reset_restart: %0d strobes dout=%h, expected 1 dout=000010", ns, cd);
        end
        // Channel 1 was cleared by reset, so a last-only beat sums from zero.
        ns = 0;
        drive(24'h000030, C_ONE, 1'b0, 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 6; k++) begin
            idle();
            if (ovld) begin ns++; cd = dout; end
        end
        n_vec++;
        if (ns != 1 || cd !== 24'h000030) begin
            n_err++;
            $display("FAIL reset_acc_zero: %0d strobes dout=%h, expected 1 dout=000030", ns, cd);
        end
    endtask

    task automatic test_bad_channel();
        int ns = 0, kk = 0;
        logic [23:0] cd = '0;
        logic [1:0] cc = '0;
        drive(24'h000010, C_ONE, 1'b1, 1'b0, 1'b0, 2'd2);
        drive(24'h500000, C_ONE, 1'b1, 1'b1, 1'b0, 2'd3);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld3) ns++;
        end
        n_vec++;
        if (ns != 0) begin
            n_err++;
            $display("FAIL bad_ch_dropped: %0d strobes on ch=3 beat, expected 0", ns);
        end
        drive(24'h000010, C_ONE, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (ovld3) begin
                ns++;
                if (ns == 1) begin kk = k; cd = dout3; cc = och3; end
            end
        end
        n_vec++;
        if (ns != 1 || kk != 3 || cd !== 24'h000020 || cc !== 2'd2) begin
            n_err++;
            $display("FAIL bad_ch_acc_kept: %0d strobes at %0d dout=%h ch=%0d, expected 1 at 3 dout=000020 ch=2",
                     ns, kk, cd, cc);
        end
    endtask

    initial begin
        rst_n = 1'b0; din = '0; coef = '0; valid = 1'b0;
        first = 1'b0; last = 1'b0; sub = 1'b0; ch = '0;
        test_reset();
        test_single_term();
        test_add_sub();
        test_interleave();
        test_saturate_round();
        test_continue();
        test_reset_mid_sum();
        test_bad_channel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_acc_bank.md
Name: mac_acc_bank

Overview:
Multi-channel, pipelined multiply-accumulate engine for the EQ filter datapath. It holds NCH independent accumulators, one per audio channel or filter section. Each one is selected per beat, so interleaved channels share one multiplier. On the last beat of a sum, the channel's result is rounded, shifted back to sample format, saturated and emitted with a valid strobe.

Parameters:
Win, 24, input sample width (signed)
Wc, 27, coefficient width (signed)
Wacc, 64, accumulator width (signed, must be >= Win+Wc)
Wout, 24, output sample width (signed)
FRAC, 23, right shift applied to the final sum (coefficient fractional bits); 0 = no shift, no rounding
NCH, 2, number of channel accumulators (>= 1)
CHW, $clog2(NCH) (min 1), channel index width (derived, not overridden)

Ports:
ic_clk  in  1  clock, all logic on rising edge
ic_rst_n  in  1  synchronous reset, active low
id_din  in  Win  input sample
id_coef  in  Wc  coefficient
ic_valid  in  1  beat valid; all other inputs sampled only when high
ic_first  in  1  first term of a sum: accumulator loaded, not added
ic_last  in  1  last term of a sum: result emitted
ic_sub  in  1  1 = subtract product, 0 = add product
ic_ch  in  CHW  target accumulator index
od_dout  out  Wout  rounded, saturated result
oc_valid  out  1  one-cycle strobe, od_dout/oc_ch/oc_sat valid
oc_ch  out  CHW  channel of the emitted result
oc_sat  out  1  result was clipped this strobe

Behaviour:
- Reset: synchronous, active-low. While ic_rst_n=0 on a rising edge: all accumulators, pipeline valids, od_dout, oc_ch, oc_sat and oc_valid go to 0.
- Reset mid-operation: in-flight beats are discarded with no oc_valid. The next sum must start with ic_first. The block always accepts input; there is no backpressure.
- Pipeline (S1..S4), one beat per cycle:
  - S1 registers all inputs and controls.
  - S2 registers the full-precision product din*coef (Win+Wc bits), sign-extended to Wacc.
  - S3 performs the read-modify-write of acc[ch]: first ? (sub ? -p : p) : (sub ? acc-p : acc+p).
  - S4 applies round/shift/saturate to the S3 new value when last=1.
- Latency: a beat with ic_valid=1 and ic_last=1 presented at edge t gives oc_valid=1 in the cycle after edge t+3, i.e. 4 cycles later.
- Same-channel back-to-back beats: the S3 read-modify-write completes in one cycle, so there is no hazard and no stall. Any interleaving across channels is legal.
- Accumulator arithmetic: two's complement mod 2^Wacc, wraps silently, no saturation inside the accumulator.
- Output format:
  - If FRAC>0, add 2^(FRAC-1) (round half toward +inf), then arithmetic shift right by FRAC.
  - Saturate to [-2^(Wout-1), 2^(Wout-1)-1].
  - oc_sat=1 iff clipping occurred.
- ic_first and ic_last in the same beat: a single-term sum, emitted normally.
- ic_last without a prior ic_first on that channel: adds to the current accumulator contents (post-reset value is 0).
- ic_ch >= NCH (non-power-of-2 NCH only): the beat is dropped. No accumulator changes and no oc_valid.
- The accumulator keeps the final sum after ic_last; a later beat without ic_first continues from it.
- Outputs hold their last values between strobes; only oc_valid pulses.

Test Plan:
1. Single term, defaults: ch0, din=0x400000, coef=0x0800000 (1.0), first=last=1 -> 4 cycles later oc_valid=1, od_dout=0x400000, oc_ch=0, oc_sat=0.
2. Add/sub sum, ch1: three beats, din=0x100000, coef=0x0800000; first on beat 1, sub=1 on beat 3, last on beat 3 -> od_dout=0x100000, single oc_valid strobe.
3. Interleave: alternate ch0/ch1 each cycle for 4 beats, ch0 din=0x200000 and ch1 din=0xE00000, coef=1.0, first on the first beat and last on the final beat of each channel -> ch0 0x400000 then ch1 0xC00000 on consecutive cycles, oc_ch 0 then 1.
4. Saturation: din=0x7FFFFF, coef=0x3FFFFFF -> od_dout=0x7FFFFF, oc_sat=1. din=0x800000, coef=0x3FFFFFF -> od_dout=0x800000, oc_sat=1.
5. Rounding: din=1, coef=0x0400000 (0.5) -> od_dout=0x000001. din=0xFFFFFF (-1), same coef -> od_dout=0x000000, oc_sat=0.
6. Reset mid-sum: two beats issued on ch0, then ic_rst_n=0 for 1 cycle -> no oc_valid. A new first=last beat din=0x000010, coef=1.0 -> od_dout=0x000010. With NCH=3, a beat on ch=3 -> no strobe and acc unchanged.
